// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises board reset deassertion, holds all channels in reset for
// HOLD_CYCLES, releases them one by one STAGGER_CYCLES apart, then serves per-channel soft
// reset pulses of HOLD_CYCLES length while in RUN.
// Optional feature macro RESET_SEQ_RETRIGGER_EN: a soft request on a channel whose pulse is
// still active reloads that channel's pulse counter instead of being ignored.
module reset_sequencer #(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic            clk,
  input  logic            PCB_RST,
  input  logic [N_CH-1:0] rst_req,
  output logic [N_CH-1:0] reset,
  output logic            ready
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned SW = $clog2(STAGGER_CYCLES + 1);
  localparam int unsigned CW = $clog2(N_CH + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

`ifdef RESET_SEQ_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  typedef enum logic [1:0] {StReset, StHold, StStagger, StRun} state_t;

  state_t          state;
  logic            rst_meta;
  logic            rst_s;
  logic [N_CH-1:0] req_meta;
  logic [N_CH-1:0] req_sync;
  logic [N_CH-1:0] req_prev;
  logic [N_CH-1:0] req_rise;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   stag_cnt;
  logic [CW-1:0]   ch_idx;
  logic [HW-1:0]   pulse_cnt [N_CH];
  logic            hold_done;

  // Board reset asserts immediately, deasserts through two flops.
  always_ff @(posedge clk or posedge PCB_RST) begin
    if (PCB_RST) begin
      rst_meta <= 1'b1;
      rst_s    <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_s    <= rst_meta;
    end
  end

  // Per-channel request synchroniser plus edge register.
  always_ff @(posedge clk or posedge PCB_RST) begin
    if (PCB_RST) begin
      req_meta <= '0;
      req_sync <= '0;
      req_prev <= '0;
    end else begin
      req_meta <= rst_req;
      req_sync <= req_meta;
      req_prev <= req_sync;
    end
  end

  assign req_rise = req_sync & ~req_prev;

  // HOLD is entered one edge after rst_s falls, so that edge already counts as the first
  // hold cycle; with a one-cycle hold channel 0 is released straight out of RESET.
  assign hold_done = (HOLD_CYCLES == 1) ? (state == StReset && !rst_s)
                                        : (state == StHold && hold_cnt == HOLD_LAST);

  // Sequencer FSM with registered reset/ready outputs and soft-pulse counters.
  always_ff @(posedge clk or posedge PCB_RST) begin
    if (PCB_RST) begin
      state    <= StReset;
      reset    <= '1;
      ready    <= 1'b0;
      hold_cnt <= '0;
      stag_cnt <= '0;
      ch_idx   <= '0;
      for (int i = 0; i < N_CH; i++) pulse_cnt[i] <= '0;
    end else begin
      unique case (state)
        StReset, StHold: begin
          if (hold_done) begin
            reset[0] <= 1'b0;
            hold_cnt <= '0;
            if (N_CH == 1) begin
              state <= StRun;
              ready <= 1'b1;
            end else begin
              state    <= StStagger;
              ch_idx   <= CW'(1);
              stag_cnt <= '0;
            end
          end else if (state == StHold) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else if (!rst_s) begin
            state    <= StHold;
            hold_cnt <= HW'(1);
          end
        end
        StStagger: begin
          if (stag_cnt == STAG_LAST) begin
            stag_cnt <= '0;
            for (int i = 0; i < N_CH; i++) begin
              if (CW'(i) == ch_idx) reset[i] <= 1'b0;
            end
            if (ch_idx == CH_LAST) begin
              state <= StRun;
              ready <= 1'b1;
            end else begin
              ch_idx <= ch_idx + CW'(1);
            end
          end else begin
            stag_cnt <= stag_cnt + SW'(1);
          end
        end
        StRun: begin
          // A channel's reset bit in RUN is high only while its soft pulse runs.
          for (int i = 0; i < N_CH; i++) begin
            if (req_rise[i] && (!reset[i] || RETRIGGER)) begin
              reset[i]     <= 1'b1;
              pulse_cnt[i] <= HOLD_LAST;
            end else if (reset[i]) begin
              if (pulse_cnt[i] == '0) reset[i] <= 1'b0;
              else                    pulse_cnt[i] <= pulse_cnt[i] - HW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an edge-count model derives release times and soft-pulse
// windows, checked every clock, plus directed literal checks at key edges.
module tb_reset_sequencer;

  localparam int N      = 3;
  localparam int H      = 8;
  localparam int S      = 4;
  localparam int E_LAST = 2 + H + (N - 1) * S;

`ifdef RESET_SEQ_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         PCB_RST = 1'b0;
  logic [N-1:0] rst_req = '0;
  logic [N-1:0] reset;
  logic         ready;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: k = edges since board reset release (0 while in reset).
  int           k = 0;
  int           pend[N];
  int           det_at[N];
  logic [N-1:0] prev;

  reset_sequencer #(
    .N_CH          (N),
    .HOLD_CYCLES   (H),
    .STAGGER_CYCLES(S)
  ) dut (
    .clk    (clk),
    .PCB_RST(PCB_RST),
    .rst_req(rst_req),
    .reset  (reset),
    .ready  (ready)
  );

  initial forever #5 clk = ~clk;

  // Model and per-cycle compare.
  initial begin
    logic [N-1:0] exp_r;
    logic         exp_rdy;
    prev = '0;
    for (int i = 0; i < N; i++) begin
      pend[i]   = 0;
      det_at[i] = -1;
    end
    forever begin
      @(posedge clk);
      if (PCB_RST) begin
        k    = 0;
        prev = '0;
        for (int i = 0; i < N; i++) begin
          pend[i]   = 0;
          det_at[i] = -1;
        end
      end else begin
        k++;
        for (int i = 0; i < N; i++) begin
          if (det_at[i] == k) begin
            det_at[i] = -1;
            if (k > E_LAST) begin
              if (k > pend[i])  pend[i] = k + H;
              else if (RETRIG)  pend[i] = k + H;
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          if (rst_req[i] && !prev[i]) det_at[i] = k + 2;
        end
        prev = rst_req;
      end
      #1;
      for (int i = 0; i < N; i++) exp_r[i] = (k < 2 + H + i * S) || (k < pend[i]);
      exp_rdy = (k >= E_LAST);
      vectors++;
      if (reset !== exp_r || ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL model k=%0d: reset=%b ready=%b, expected reset=%b ready=%b",
                 k, reset, ready, exp_r, exp_rdy);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [N-1:0] er, input logic erdy);
    #1;
    vectors++;
    if (reset !== er || ready !== erdy) begin
      miscompares++;
      $display("FAIL %s: reset=%b ready=%b, expected reset=%b ready=%b",
               name, reset, ready, er, erdy);
    end
  endtask

  initial begin
    logic [N-1:0] retrig_exp;
    retrig_exp = RETRIG ? 3'b010 : 3'b000;

    // Power-up, with a request during HOLD that must be discarded.
    #2 PCB_RST = 1'b1;
    step(3);
    chk("reset_state", 3'b111, 1'b0);
    PCB_RST = 1'b0;
    step(4);
    rst_req[2] = 1'b1;
    step(5);
    chk("edge9_all_held", 3'b111, 1'b0);
    rst_req[2] = 1'b0;
    step(1);
    chk("edge10_ch0_rel", 3'b110, 1'b0);
    step(3);
    chk("edge13_ch1_held", 3'b110, 1'b0);
    step(1);
    chk("edge14_ch1_rel", 3'b100, 1'b0);
    step(3);
    chk("edge17_ch2_held", 3'b100, 1'b0);
    step(1);
    chk("edge18_ready", 3'b000, 1'b1);
    step(4);

    // Single soft pulse on channel 1 (rise after edge 22, detected at edge 25).
    rst_req[1] = 1'b1;
    step(2);
    chk("soft_pre_detect", 3'b000, 1'b1);
    step(1);
    chk("soft_detect", 3'b010, 1'b1);
    rst_req[1] = 1'b0;
    step(7);
    chk("soft_last_high", 3'b010, 1'b1);
    step(1);
    chk("soft_end", 3'b000, 1'b1);

    // Second request 4 cycles into an active pulse (detections at 38 and 42).
    step(2);
    rst_req[1] = 1'b1;
    step(2);
    rst_req[1] = 1'b0;
    step(2);
    rst_req[1] = 1'b1;
    step(2);
    rst_req[1] = 1'b0;
    step(4);
    chk("retrig_edge45", 3'b010, 1'b1);
    step(1);
    chk("retrig_edge46", retrig_exp, 1'b1);
    step(3);
    chk("retrig_edge49", retrig_exp, 1'b1);
    step(1);
    chk("retrig_edge50", 3'b000, 1'b1);

    // Simultaneous requests on channels 0 and 2 (detected at edge 55).
    step(2);
    rst_req = 3'b101;
    step(3);
    chk("dual_detect", 3'b101, 1'b1);
    rst_req = 3'b000;
    step(7);
    chk("dual_last_high", 3'b101, 1'b1);
    step(1);
    chk("dual_end", 3'b000, 1'b1);

    // Asynchronous assertion in RUN, then a restart aborted mid-STAGGER.
    step(2);
    PCB_RST = 1'b1;
    chk("async_in_run", 3'b111, 1'b0);
    step(2);
    PCB_RST = 1'b0;
    step(14);
    chk("restart_edge14", 3'b100, 1'b0);
    PCB_RST = 1'b1;
    chk("async_mid_stagger", 3'b111, 1'b0);
    step(3);
    PCB_RST = 1'b0;
    step(9);
    chk("rerun_edge9", 3'b111, 1'b0);
    step(1);
    chk("rerun_edge10", 3'b110, 1'b0);
    step(8);
    chk("rerun_edge18", 3'b000, 1'b1);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
